// File: rtl/divider_defs.sv
// -----------------------------------------------------------------------------
// divider_defs
// Shared constants for the restoring divider: operand widths, the number of
// restoring steps per division, the step-counter width and the FSM encoding.
// No ports; imported by restoring_divider and subtractor_9.
// -----------------------------------------------------------------------------
package divider_defs;

    localparam int DIV_NW    = 16;              // dividend / quotient width
    localparam int DIV_DW    = 8;               // divisor / remainder width
    localparam int DIV_STEPS = 16;              // one restoring step per quotient bit
    localparam int DIV_CNT_W = 4;               // wide enough to count DIV_STEPS steps
    localparam int DIV_SUB_W = DIV_DW + 1;      // trial subtraction width

    localparam logic [DIV_CNT_W-1:0] DIV_LAST_STEP = DIV_CNT_W'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell used to build ripple arithmetic.
// Ports:
//   a_i, b_i  : addend bits
//   cin_i     : carry in
//   sum_o     : sum bit
//   cout_o    : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/subtractor_9.sv
// -----------------------------------------------------------------------------
// subtractor_9
// 9-bit ripple subtractor: diff = a - b, formed as a + ~b + 1 through a chain
// of full_adder cells. cout_o = 1 means no borrow, i.e. a >= b and the
// difference is non-negative.
// Ports:
//   a_i    : minuend (9 bits)
//   b_i    : subtrahend (9 bits)
//   diff_o : a - b modulo 2^9
//   cout_o : 1 when the difference is non-negative
// -----------------------------------------------------------------------------
module subtractor_9
    import divider_defs::*;
(
    input  logic [DIV_SUB_W-1:0] a_i,
    input  logic [DIV_SUB_W-1:0] b_i,
    output logic [DIV_SUB_W-1:0] diff_o,
    output logic                 cout_o
);

    logic [DIV_SUB_W:0] carry;

    // Carry-in of 1 completes the two's complement of b.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIV_SUB_W; i++) begin : g_ripple
        full_adder u_fa (
            .a_i    (a_i[i]),
            .b_i    (~b_i[i]),
            .cin_i  (carry[i]),
            .sum_o  (diff_o[i]),
            .cout_o (carry[i+1])
        );
    end

    assign cout_o = carry[DIV_SUB_W];

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Multi-cycle unsigned 16/8 restoring divider. One quotient bit is resolved
// per clock over 16 RUN cycles; a zero divisor bypasses RUN and reports
// quotient all-ones, remainder = low byte of the dividend, dbz = 1.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   start     : request pulse, only looked at while IDLE
//   dividend  : 16-bit unsigned numerator, captured on acceptance
//   divisor   : 8-bit unsigned denominator, captured on acceptance
//   busy      : high throughout RUN
//   done      : one-cycle strobe marking a fresh result
//   quotient  : 16-bit quotient, held between done strobes
//   remainder : 8-bit remainder, held between done strobes
//   dbz       : divide-by-zero flag of the last completed operation
// -----------------------------------------------------------------------------
module restoring_divider
    import divider_defs::*;
#(
    parameter int NW = DIV_NW,
    parameter int DW = DIV_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          dbz
);

    state_t                 state_q, state_d;
    logic [DW:0]            r_q,     r_d;      // partial remainder
    logic [NW-1:0]          q_q,     q_d;      // dividend shifting out / quotient shifting in
    logic [DW-1:0]          d_q,     d_d;      // latched divisor
    logic [DIV_CNT_W-1:0]   cnt_q,   cnt_d;
    logic [NW-1:0]          quot_q,  quot_d;
    logic [DW-1:0]          rem_q,   rem_d;
    logic                   dbz_q,   dbz_d;

    logic [DW:0]            trial;
    logic [DW:0]            diff;
    logic                   sub_cout;
    logic                   nonneg;
    logic [DW:0]            r_step;
    logic [NW-1:0]          q_step;

    // ---- single restoring step ---------------------------------------------
    assign trial = {r_q[DW-1:0], q_q[NW-1]};

    subtractor_9 u_sub (
        .a_i    (trial),
        .b_i    ({1'b0, d_q}),
        .diff_o (diff),
        .cout_o (sub_cout)
    );

    // R stays below D after every step, so r_q[DW] is always 0 and the 9-bit
    // trial is exact. Should it ever be set, the true shifted value would be
    // at least 2^9 > D, so the step is non-negative regardless of the borrow.
    assign nonneg = sub_cout | r_q[DW];
    assign r_step = nonneg ? diff : trial;
    assign q_step = {q_q[NW-2:0], nonneg};

    // ---- next-state / datapath control -------------------------------------
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    r_d   = '0;
                    q_d   = dividend;
                    d_d   = divisor;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = dividend[DW-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                // Results are published on the same edge that enters DONE so
                // they are visible exactly while done is high.
                if (cnt_q == DIV_LAST_STEP) begin
                    state_d = ST_DONE;
                    quot_d  = q_step;
                    rem_d   = r_step[DW-1:0];
                    dbz_d   = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- state registers ---------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
// Scoreboard bench for restoring_divider. Each accepted request pushes its
// expected quotient/remainder/dbz and the cycle in which done must appear;
// a negedge monitor pops and compares on every done and checks that results
// hold between strobes.
// -----------------------------------------------------------------------------
module tb_restoring_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    restoring_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] last_q   = '0;
    logic [7:0]  last_r   = '0;
    logic        last_dbz = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive a request in the current cycle (caller sits #1 after an edge),
    // record its expectation, then drop start and scramble the operands.
    task automatic drive_op(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (b == 8'd0) begin
            e.q = 16'hFFFF; e.r = a[7:0]; e.dbz = 1'b1; e.cyc = cyc + 1;
        end else begin
            e.q = a / 16'(b); e.r = 8'(a % 16'(b)); e.dbz = 1'b0; e.cyc = cyc + 17;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            next_cycle();
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Result monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_q = '0; last_r = '0; last_dbz = 1'b0;
            end else if (done) begin
                chk("busy_with_done", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                    last_q = quotient; last_r = remainder; last_dbz = dbz;
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("quotient",   32'(quotient),  32'(e.q));
                    chk("remainder",  32'(remainder), 32'(e.r));
                    chk("dbz",        32'(dbz),       32'(e.dbz));
                    last_q = e.q; last_r = e.r; last_dbz = e.dbz;
                end
            end else begin
                chk("hold", {7'd0, dbz, remainder, quotient}, {7'd0, last_dbz, last_r, last_q});
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        int          n_sweep;

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem",  32'(remainder), 32'd0);
        chk("rst_dbz",  32'(dbz), 32'd0);
        rst_n = 1'b1;

        // Directed operations.
        next_cycle();
        drive_op(16'd1000, 8'd7);
        chk("busy_after_accept", 32'(busy), 32'd1);
        drain();
        next_cycle(); drive_op(16'd65535, 8'd255); drain();
        next_cycle(); drive_op(16'd65535, 8'd1);   drain();
        next_cycle(); drive_op(16'd3, 8'd10);      drain();
        next_cycle(); drive_op(16'd5, 8'd0);
        chk("dbz_busy", 32'(busy), 32'd0);
        drain();

        // A start arriving mid-operation must be lost.
        next_cycle(); drive_op(16'd1000, 8'd7);
        repeat (4) next_cycle();
        start = 1'b1; dividend = 16'd9; divisor = 8'd3;
        next_cycle();
        start = 1'b0;
        drain();
        repeat (25) next_cycle();

        // Reset in the middle of RUN aborts with no done.
        drive_op(16'd1000, 8'd7);
        repeat (6) next_cycle();
        rst_n = 1'b0;
        next_cycle();
        sb.delete();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quot", 32'(quotient), 32'd0);
        chk("abort_rem",  32'(remainder), 32'd0);
        chk("abort_dbz",  32'(dbz), 32'd0);
        rst_n = 1'b1;
        drive_op(16'd81, 8'd9);
        drain();
        repeat (3) next_cycle();

        // Back-to-back sweep with start tied high; operands are junk outside
        // each acceptance cycle, which comes every 18 cycles.
        n_sweep = 2000;
        for (int i = 0; i < n_sweep; i++) begin
            exp_t e;
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            if (i == 0) begin a = 16'hFFFF; b = 8'd1; end
            if (i == 1) begin a = 16'd0;    b = 8'd255; end
            if (i == 2) begin a = 16'd254;  b = 8'd255; end
            start = 1'b1; dividend = a; divisor = b;
            e.q = a / 16'(b); e.r = 8'(a % 16'(b)); e.dbz = 1'b0; e.cyc = cyc + 17;
            sb.push_back(e);
            for (int k = 0; k < 17; k++) begin
                next_cycle();
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            next_cycle();
        end
        start = 1'b0;
        drain();
        repeat (5) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
